// File: rtl/render_pkg.sv
// Shared types and helpers for the render pipeline: scheduler state encoding,
// framebuffer sizing and the depth clear value.
package render_pkg;

  typedef enum logic [2:0] {
    SCHED_IDLE   = 3'd0,
    SCHED_CLEAR  = 3'd1,
    SCHED_FETCH  = 3'd2,
    SCHED_LAUNCH = 3'd3,
    SCHED_WAIT   = 3'd4,
    SCHED_SWAP   = 3'd5
  } sched_state_t;

  localparam int DEPTH_BIT_WIDTH_DEF = 16;
  localparam logic [DEPTH_BIT_WIDTH_DEF-1:0] DEPTH_FAR = '1;

  function automatic int fb_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/fb_clear_sweeper.sv
// Linear address sweeper for buffer clears: one address per cycle from 0 to
// PIXELS-1 after a start pulse. Shared by the depth and color clears.
module fb_clear_sweeper #(
  parameter int PIXELS = 57600,
  parameter int AW     = $clog2(PIXELS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start,
  output logic [AW-1:0] addr,
  output logic          active,
  output logic          last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active <= 1'b0;
      addr   <= '0;
    end else if (start) begin
      active <= 1'b1;
      addr   <= '0;
    end else if (active) begin
      // Park the address at 0 once the sweep ends so idle output is quiet.
      if (addr == LAST_ADDR) begin
        active <= 1'b0;
        addr   <= '0;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

  assign last = active && (addr == LAST_ADDR);

endmodule

// File: rtl/render_scheduler.sv
// Per-frame sequencer: depth clear, then one triangle at a time through the
// rasterizer (start/done with timeout), then a buffer swap pulse.
module render_scheduler
  import render_pkg::*;
#(
  parameter int FB_WIDTH        = 320,
  parameter int FB_HEIGHT       = 180,
  parameter int DEPTH_BIT_WIDTH = DEPTH_BIT_WIDTH_DEF,
  parameter int TRI_IDX_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES  = 1 << 20
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     frame_start,
  input  logic [TRI_IDX_WIDTH-1:0]                 tri_count,
  input  logic                                     raster_busy,
  input  logic                                     raster_done,
  output logic                                     raster_start,
  output logic [TRI_IDX_WIDTH-1:0]                 tri_index,
  output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]    clear_addr,
  output logic                                     clear_we,
  output logic [DEPTH_BIT_WIDTH-1:0]               clear_data,
  output logic                                     buf_swap,
  output logic                                     busy,
  output logic [TRI_IDX_WIDTH-1:0]                 tris_drawn,
  output logic                                     raster_timeout,
  output logic                                     frame_overrun,
  output logic [2:0]                               state_dbg
);

  // Rasterizer handshake: raster_start is a single-cycle request issued only
  // while raster_busy is low; raster_done is a single-cycle completion pulse
  // that is only honoured once the scheduler is in WAIT.

  localparam int PIXELS = fb_pixels(FB_WIDTH, FB_HEIGHT);
  localparam int AW     = $clog2(PIXELS);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = SCHED_IDLE;
  localparam logic [2:0] ST_CLEAR  = SCHED_CLEAR;
  localparam logic [2:0] ST_FETCH  = SCHED_FETCH;
  localparam logic [2:0] ST_LAUNCH = SCHED_LAUNCH;
  localparam logic [2:0] ST_WAIT   = SCHED_WAIT;
  localparam logic [2:0] ST_SWAP   = SCHED_SWAP;

  logic [2:0]               state;
  logic [TRI_IDX_WIDTH-1:0] tri_cnt_q;
  logic [TW-1:0]            to_cnt;
  logic                     sweep_start;
  logic                     sweep_last;
  logic [AW-1:0]            sweep_addr;
  logic                     sweep_active;

  assign sweep_start = (state == ST_IDLE) && frame_start;

  fb_clear_sweeper #(
    .PIXELS (PIXELS),
    .AW     (AW)
  ) u_depth_sweep (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (sweep_start),
    .addr   (sweep_addr),
    .active (sweep_active),
    .last   (sweep_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= ST_IDLE;
      tri_cnt_q      <= '0;
      tri_index      <= '0;
      tris_drawn     <= '0;
      to_cnt         <= '0;
      raster_timeout <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      if (frame_start && (state != ST_IDLE)) frame_overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            tri_cnt_q  <= tri_count;
            tris_drawn <= '0;
            tri_index  <= '0;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (sweep_last) state <= (tri_cnt_q != '0) ? ST_FETCH : ST_SWAP;
        end
        ST_FETCH: state <= ST_LAUNCH;
        ST_LAUNCH: begin
          if (!raster_busy) begin
            to_cnt <= '0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A timed-out triangle is abandoned but still counted as drawn.
          if (raster_done || (to_cnt == TO_LAST)) begin
            if (!raster_done) raster_timeout <= 1'b1;
            tris_drawn <= tris_drawn + 1'b1;
            if (tri_index == tri_cnt_q - 1'b1) begin
              state <= ST_SWAP;
            end else begin
              tri_index <= tri_index + 1'b1;
              state     <= ST_FETCH;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_SWAP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign raster_start = (state == ST_LAUNCH) && !raster_busy;
  assign buf_swap     = (state == ST_SWAP);
  assign busy         = (state != ST_IDLE);
  assign clear_we     = sweep_active;
  assign clear_addr   = sweep_addr;
  assign clear_data   = {DEPTH_BIT_WIDTH{1'b1}};
  assign state_dbg    = state;

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler on a 4x2 framebuffer with a 16-cycle timeout and
// a rasterizer model that answers 5 cycles after each start.
module tb_render_scheduler;

  localparam int FB_W = 4;
  localparam int FB_H = 2;
  localparam int NPIX = FB_W * FB_H;
  localparam int AW   = $clog2(NPIX);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd3;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b1;
  logic           frame_start = 1'b0;
  logic [7:0]     tri_count = '0;
  logic           raster_busy;
  logic           raster_done = 1'b0;
  logic           raster_start;
  logic [7:0]     tri_index;
  logic [AW-1:0]  clear_addr;
  logic           clear_we;
  logic [15:0]    clear_data;
  logic           buf_swap;
  logic           busy;
  logic [7:0]     tris_drawn;
  logic           raster_timeout;
  logic           frame_overrun;
  logic [2:0]     state_dbg;

  render_scheduler #(
    .FB_WIDTH        (FB_W),
    .FB_HEIGHT       (FB_H),
    .DEPTH_BIT_WIDTH (16),
    .TRI_IDX_WIDTH   (8),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .frame_start    (frame_start),
    .tri_count      (tri_count),
    .raster_busy    (raster_busy),
    .raster_done    (raster_done),
    .raster_start   (raster_start),
    .tri_index      (tri_index),
    .clear_addr     (clear_addr),
    .clear_we       (clear_we),
    .clear_data     (clear_data),
    .buf_swap       (buf_swap),
    .busy           (busy),
    .tris_drawn     (tris_drawn),
    .raster_timeout (raster_timeout),
    .frame_overrun  (frame_overrun),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  // ---------------- rasterizer model ----------------
  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  assign raster_busy = model_busy | hold_busy;

  int   hang_idx = -1;
  int   rcnt = 0;
  logic saw_start = 1'b0;
  int   saw_idx = 0;
  logic hang_cur = 1'b0;

  always @(negedge clk_in) begin
    saw_start = raster_start;
    saw_idx   = int'(tri_index);
  end

  always @(posedge clk_in) begin
    #1;
    raster_done = 1'b0;
    if (rst_in) begin
      model_busy = 1'b0;
      rcnt       = 0;
    end else if (saw_start) begin
      model_busy = 1'b1;
      rcnt       = 4;
      hang_cur   = (saw_idx == hang_idx);
    end else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        model_busy  = 1'b0;
        raster_done = !hang_cur;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_clear_q[$];
  logic [7:0]    exp_tri_q[$];
  int start_cnt, swap_cnt, fs_cyc, first_clear_cyc, first_start_cyc;
  int last_start_cyc, swap_cyc, first_to_cyc;

  always @(negedge clk_in) begin
    logic [AW-1:0] ea;
    logic [7:0]    et;
    if (clear_we) begin
      n_cmp++;
      if (exp_clear_q.size() == 0) begin
        n_err++;
        $display("FAIL clear_unexpected: addr=%0d required no write", clear_addr);
      end else begin
        ea = exp_clear_q.pop_front();
        if (clear_addr !== ea) begin
          n_err++;
          $display("FAIL clear_addr: got %0d required %0d", clear_addr, ea);
        end
      end
      if (first_clear_cyc < 0) first_clear_cyc = cyc;
    end
    if (raster_start) begin
      n_cmp++;
      if (exp_tri_q.size() == 0) begin
        n_err++;
        $display("FAIL start_unexpected: tri_index=%0d required no start", tri_index);
      end else begin
        et = exp_tri_q.pop_front();
        if (tri_index !== et) begin
          n_err++;
          $display("FAIL start_tri_index: got %0d required %0d", tri_index, et);
        end
      end
      n_cmp++;
      if (raster_busy !== 1'b0) begin
        n_err++;
        $display("FAIL start_while_busy: raster_busy=%b required 0", raster_busy);
      end
      start_cnt++;
      if (first_start_cyc < 0) first_start_cyc = cyc;
      last_start_cyc = cyc;
    end
    if (buf_swap) begin
      swap_cnt++;
      swap_cyc = cyc;
    end
    if (raster_timeout && first_to_cyc < 0) first_to_cyc = cyc;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    start_cnt = 0; swap_cnt = 0; first_clear_cyc = -1; first_start_cyc = -1;
    last_start_cyc = -1; swap_cyc = -1; first_to_cyc = -1;
  endtask

  task automatic start_frame(input int count);
    clear_stats();
    for (int a = 0; a < NPIX; a++) exp_clear_q.push_back(AW'(a));
    for (int t = 0; t < count; t++) exp_tri_q.push_back(8'(t));
    @(negedge clk_in);
    frame_start = 1'b1;
    tri_count   = 8'(count);
    fs_cyc      = cyc;
    @(negedge clk_in);
    frame_start = 1'b0;
  endtask

  task automatic wait_swaps(input int target, input int budget, output bit ok);
    int i = 0;
    while (swap_cnt < target && i < budget) begin
      @(negedge clk_in);
      i++;
    end
    @(negedge clk_in);
    ok = (swap_cnt >= target);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    n_cmp++; if ({raster_start, clear_we, buf_swap, busy, raster_timeout, frame_overrun} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 000000",
        {raster_start, clear_we, buf_swap, busy, raster_timeout, frame_overrun}); end
    n_cmp++; if ({tri_index, tris_drawn, clear_addr} !== '0) begin
      n_err++; $display("FAIL reset_counts: idx=%0d drawn=%0d addr=%0d required 0", tri_index, tris_drawn, clear_addr); end
    n_cmp++; if (clear_data !== 16'hFFFF) begin n_err++; $display("FAIL clear_data: got %h required ffff", clear_data); end
  endtask

  task automatic test_three_tris();
    bit ok;
    start_frame(3);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy_high: got %b required 1", busy); end
    wait_swaps(1, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL t1_swap_timeout: swaps=%0d required 1", swap_cnt); end
    n_cmp++; if (first_clear_cyc - fs_cyc !== 1) begin n_err++; $display("FAIL t1_clear_latency: got %0d required 1", first_clear_cyc - fs_cyc); end
    n_cmp++; if (first_start_cyc - fs_cyc !== NPIX + 2) begin n_err++; $display("FAIL t1_start_latency: got %0d required %0d", first_start_cyc - fs_cyc, NPIX + 2); end
    n_cmp++; if (swap_cyc - last_start_cyc !== 6) begin n_err++; $display("FAIL t1_swap_latency: got %0d required 6", swap_cyc - last_start_cyc); end
    n_cmp++; if (start_cnt !== 3 || swap_cnt !== 1) begin n_err++; $display("FAIL t1_counts: starts=%0d swaps=%0d required 3/1", start_cnt, swap_cnt); end
    n_cmp++; if (tris_drawn !== 8'd3) begin n_err++; $display("FAIL t1_tris_drawn: got %0d required 3", tris_drawn); end
    n_cmp++; if (exp_clear_q.size() != 0 || exp_tri_q.size() != 0) begin n_err++; $display("FAIL t1_leftover: clears=%0d tris=%0d required 0/0", exp_clear_q.size(), exp_tri_q.size()); end
    n_cmp++; if (busy !== 1'b0 || raster_timeout !== 1'b0 || frame_overrun !== 1'b0) begin n_err++; $display("FAIL t1_end_flags: busy=%b to=%b ovr=%b required 000", busy, raster_timeout, frame_overrun); end
  endtask

  task automatic test_zero_tris();
    bit ok;
    start_frame(0);
    wait_swaps(1, 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL t2_swap_timeout: swaps=%0d required 1", swap_cnt); end
    n_cmp++; if (swap_cyc - fs_cyc !== NPIX + 1) begin n_err++; $display("FAIL t2_swap_latency: got %0d required %0d", swap_cyc - fs_cyc, NPIX + 1); end
    n_cmp++; if (start_cnt !== 0 || tris_drawn !== 8'd0) begin n_err++; $display("FAIL t2_no_tris: starts=%0d drawn=%0d required 0/0", start_cnt, tris_drawn); end
    n_cmp++; if (exp_clear_q.size() != 0) begin n_err++; $display("FAIL t2_clears: left=%0d required 0", exp_clear_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    hang_idx = 0;
    start_frame(2);
    wait_swaps(1, 300, ok);
    hang_idx = -1;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL t3_swap_timeout: swaps=%0d required 1", swap_cnt); end
    n_cmp++; if (raster_timeout !== 1'b1) begin n_err++; $display("FAIL t3_timeout_flag: got %b required 1", raster_timeout); end
    n_cmp++; if (first_to_cyc - first_start_cyc !== 17) begin n_err++; $display("FAIL t3_timeout_latency: got %0d required 17", first_to_cyc - first_start_cyc); end
    n_cmp++; if (last_start_cyc - first_start_cyc !== 18) begin n_err++; $display("FAIL t3_relaunch: got %0d required 18", last_start_cyc - first_start_cyc); end
    n_cmp++; if (start_cnt !== 2 || tris_drawn !== 8'd2) begin n_err++; $display("FAIL t3_counts: starts=%0d drawn=%0d required 2/2", start_cnt, tris_drawn); end
  endtask

  task automatic test_overrun();
    bit ok;
    int i = 0;
    start_frame(3);
    while (start_cnt < 1 && i < 50) begin @(negedge clk_in); i++; end
    @(negedge clk_in);
    frame_start = 1'b1;
    tri_count   = 8'd7;
    @(negedge clk_in);
    frame_start = 1'b0;
    n_cmp++; if (frame_overrun !== 1'b1) begin n_err++; $display("FAIL t4_overrun: got %b required 1", frame_overrun); end
    wait_swaps(1, 200, ok);
    repeat (20) @(negedge clk_in);
    n_cmp++; if (swap_cnt !== 1 || start_cnt !== 3) begin n_err++; $display("FAIL t4_counts: swaps=%0d starts=%0d required 1/3", swap_cnt, start_cnt); end
    n_cmp++; if (tris_drawn !== 8'd3 || exp_tri_q.size() != 0) begin n_err++; $display("FAIL t4_tris: drawn=%0d left=%0d required 3/0", tris_drawn, exp_tri_q.size()); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int i = 0;
    start_frame(2);
    while (!(clear_we && clear_addr == AW'(3)) && i < 20) begin @(negedge clk_in); i++; end
    rst_in = 1'b1;
    @(negedge clk_in);
    n_cmp++; if (clear_we !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_err++; $display("FAIL t5_reset_stop: we=%b busy=%b state=%0d required 0/0/0", clear_we, busy, state_dbg); end
    n_cmp++; if (raster_timeout !== 1'b0 || frame_overrun !== 1'b0 || buf_swap !== 1'b0) begin
      n_err++; $display("FAIL t5_flags: to=%b ovr=%b swap=%b required 000", raster_timeout, frame_overrun, buf_swap); end
    n_cmp++; if (exp_clear_q.size() != NPIX - 4) begin n_err++; $display("FAIL t5_clear_progress: left=%0d required %0d", exp_clear_q.size(), NPIX - 4); end
    exp_clear_q.delete();
    exp_tri_q.delete();
    rst_in = 1'b0;
    start_frame(1);
    wait_swaps(1, 100, ok);
    n_cmp++; if (!ok || start_cnt !== 1 || tris_drawn !== 8'd1) begin n_err++; $display("FAIL t5_restart: swaps=%0d starts=%0d drawn=%0d required 1/1/1", swap_cnt, start_cnt, tris_drawn); end
  endtask

  task automatic test_launch_stall();
    bit ok;
    int i = 0;
    hold_busy = 1'b1;
    start_frame(1);
    while (state_dbg !== ST_LAUNCH && i < 40) begin @(negedge clk_in); i++; end
    n_cmp++; if (state_dbg !== ST_LAUNCH) begin n_err++; $display("FAIL t6_reach_launch: state=%0d required 3", state_dbg); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (raster_start !== 1'b0) begin n_err++; $display("FAIL t6_withheld: raster_start=%b required 0", raster_start); end
      @(negedge clk_in);
    end
    hold_busy = 1'b0;
    wait_swaps(1, 100, ok);
    n_cmp++; if (!ok || start_cnt !== 1 || tris_drawn !== 8'd1) begin n_err++; $display("FAIL t6_single_start: swaps=%0d starts=%0d drawn=%0d required 1/1/1", swap_cnt, start_cnt, tris_drawn); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_three_tris();
    test_zero_tris();
    test_timeout();
    test_overrun();
    test_mid_reset();
    test_launch_stall();
    repeat (3) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
